// File: rtl/multicycle_control.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory stall, timeout and sticky error.
// Optional performance counters (cycles, retired) are enabled with `define MC_PERFCNT_EN.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [2:0]       tipo,
   input  logic [2:0]       funct3,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcsrc,
   output logic             irwrite,
   output logic             memread,
   output logic             memwrite,
   output logic [3:0]       alucontrol,
   output logic             alusrc,
   output logic             regiwrite,
   output logic             memtoreg,
   output logic             instr_done,
   output logic             err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycles,
   output logic [CNT_W-1:0] retired
);

   localparam int unsigned WAIT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_FETCH  = 3'b001,
      S_DECODE = 3'b010,
      S_EXEC   = 3'b011,
      S_MEM    = 3'b100,
      S_WB     = 3'b101,
      S_ERR    = 3'b111
   } state_t;

   localparam logic [2:0] TIPO_LW  = 3'b000;
   localparam logic [2:0] TIPO_SW  = 3'b010;
   localparam logic [2:0] TIPO_R   = 3'b011;
   localparam logic [2:0] TIPO_BEQ = 3'b110;

   localparam logic [2:0] F3_SUB = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SRL = 3'b101;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0101;

   state_t              r_state;
   state_t              w_next;
   state_t              w_retire;
   logic [2:0]          r_tipo;
   logic [2:0]          r_funct3;
   logic [WAIT_W-1:0]   r_wait;
   logic                w_legal;
   logic                w_timeout;
   logic                w_waiting;

   // Opcode legality is judged on the live IR fields during DECODE only
   always_comb begin
      w_legal = 1'b0;
      case (tipo)
         TIPO_LW, TIPO_SW, TIPO_BEQ: w_legal = 1'b1;
         TIPO_R:  w_legal = (funct3 == F3_SUB) || (funct3 == F3_XOR) || (funct3 == F3_SRL);
         default: w_legal = 1'b0;
      endcase
   end

   assign w_timeout = (r_wait == WAIT_W'(MEM_TIMEOUT - 1));
   assign w_retire  = run ? S_FETCH : S_IDLE;
   assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && (w_next == r_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_tipo   <= 3'b000;
         r_funct3 <= 3'b000;
         r_wait   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_tipo   <= tipo;
            r_funct3 <= funct3;
         end
         // Counts only consecutive stalled cycles; any state change restarts it
         r_wait <= w_waiting ? (r_wait + WAIT_W'(1)) : '0;
      end
   end

   always_comb begin
      w_next     = r_state;
      pcwrite    = 1'b0;
      pcsrc      = 1'b0;
      irwrite    = 1'b0;
      memread    = 1'b0;
      memwrite   = 1'b0;
      alucontrol = 4'b0000;
      alusrc     = 1'b0;
      regiwrite  = 1'b0;
      memtoreg   = 1'b0;
      instr_done = 1'b0;
      err        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run) w_next = S_FETCH;
         end
         S_FETCH: begin
            memread = 1'b1;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               w_next  = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_DECODE: begin
            w_next = w_legal ? S_EXEC : S_ERR;
         end
         S_EXEC: begin
            case (r_tipo)
               TIPO_R: begin
                  case (r_funct3)
                     F3_XOR:  alucontrol = ALU_XOR;
                     F3_SRL:  alucontrol = ALU_SRL;
                     default: alucontrol = ALU_SUB;
                  endcase
                  w_next = S_WB;
               end
               TIPO_BEQ: begin
                  alucontrol = ALU_SUB;
                  pcsrc      = 1'b1;
                  pcwrite    = zero;
                  instr_done = 1'b1;
                  w_next     = w_retire;
               end
               default: begin
                  alucontrol = ALU_ADD;
                  alusrc     = 1'b1;
                  w_next     = S_MEM;
               end
            endcase
         end
         S_MEM: begin
            if (r_tipo == TIPO_LW) memread  = 1'b1;
            else                   memwrite = 1'b1;
            if (mem_ready) begin
               if (r_tipo == TIPO_LW) begin
                  w_next = S_WB;
               end else begin
                  instr_done = 1'b1;
                  w_next     = w_retire;
               end
            end else if (w_timeout) begin
               w_next = S_ERR;
            end
         end
         S_WB: begin
            regiwrite  = 1'b1;
            memtoreg   = (r_tipo == TIPO_LW);
            instr_done = 1'b1;
            w_next     = w_retire;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: w_next = S_ERR;
      endcase
   end

   assign state = r_state;

`ifdef MC_PERFCNT_EN
   logic [CNT_W-1:0] r_cycles;
   logic [CNT_W-1:0] r_retired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycles  <= '0;
         r_retired <= '0;
      end else begin
         if ((r_state != S_IDLE) && (r_state != S_ERR)) r_cycles <= r_cycles + CNT_W'(1);
         if (instr_done) r_retired <= r_retired + CNT_W'(1);
      end
   end

   assign cycles  = r_cycles;
   assign retired = r_retired;
`else
   assign cycles  = '0;
   assign retired = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle check of state and every control strobe.
module tb_multicycle_control;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic [2:0]  tipo;
   logic [2:0]  funct3;
   logic        zero;
   logic        mem_ready;
   logic        pcwrite, pcsrc, irwrite, memread, memwrite;
   logic [3:0]  alucontrol;
   logic        alusrc, regiwrite, memtoreg, instr_done, err;
   logic [2:0]  state;
   logic [31:0] cycles, retired;
   logic [16:0] w_act;

   int n_tests = 0;
   int n_fail  = 0;

   multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .tipo(tipo), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .pcwrite(pcwrite), .pcsrc(pcsrc), .irwrite(irwrite),
      .memread(memread), .memwrite(memwrite), .alucontrol(alucontrol), .alusrc(alusrc),
      .regiwrite(regiwrite), .memtoreg(memtoreg), .instr_done(instr_done), .err(err),
      .state(state), .cycles(cycles), .retired(retired)
   );

   // {state, pcwrite pcsrc irwrite memread memwrite, alucontrol, alusrc regiwrite memtoreg instr_done err}
   assign w_act = {state, pcwrite, pcsrc, irwrite, memread, memwrite, alucontrol,
                   alusrc, regiwrite, memtoreg, instr_done, err};

   localparam logic [16:0] V_IDLE   = {3'b000, 5'b00000, 4'b0000, 5'b00000};
   localparam logic [16:0] V_F_WAIT = {3'b001, 5'b00010, 4'b0000, 5'b00000};
   localparam logic [16:0] V_F_RDY  = {3'b001, 5'b10110, 4'b0000, 5'b00000};
   localparam logic [16:0] V_DEC    = {3'b010, 5'b00000, 4'b0000, 5'b00000};
   localparam logic [16:0] V_E_MEM  = {3'b011, 5'b00000, 4'b0010, 5'b10000};
   localparam logic [16:0] V_E_SUB  = {3'b011, 5'b00000, 4'b0110, 5'b00000};
   localparam logic [16:0] V_E_XOR  = {3'b011, 5'b00000, 4'b0011, 5'b00000};
   localparam logic [16:0] V_E_SRL  = {3'b011, 5'b00000, 4'b0101, 5'b00000};
   localparam logic [16:0] V_E_BEQ1 = {3'b011, 5'b11000, 4'b0110, 5'b00010};
   localparam logic [16:0] V_E_BEQ0 = {3'b011, 5'b01000, 4'b0110, 5'b00010};
   localparam logic [16:0] V_M_LW   = {3'b100, 5'b00010, 4'b0000, 5'b00000};
   localparam logic [16:0] V_M_SW   = {3'b100, 5'b00001, 4'b0000, 5'b00000};
   localparam logic [16:0] V_M_SWD  = {3'b100, 5'b00001, 4'b0000, 5'b00010};
   localparam logic [16:0] V_WB_LW  = {3'b101, 5'b00000, 4'b0000, 5'b01110};
   localparam logic [16:0] V_WB_R   = {3'b101, 5'b00000, 4'b0000, 5'b01010};
   localparam logic [16:0] V_ERR    = {3'b111, 5'b00000, 4'b0000, 5'b00001};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs in the low phase, check outputs, advance past the rising edge
   task automatic step(input string tag, input logic r, input logic [2:0] t, input logic [2:0] f,
                       input logic z, input logic m, input logic [16:0] e);
      run = r; tipo = t; funct3 = f; zero = z; mem_ready = m;
      #1;
      check(tag, 32'(w_act), 32'(e));
      @(negedge clk);
   endtask

   task automatic reset_pulse(input string tag);
      rst_n = 1'b0;
      #1;
      check(tag, 32'(w_act), 32'(V_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; tipo = 3'b000; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      check("reset_idle", 32'(w_act), 32'(V_IDLE));
      rst_n = 1'b1;
      step("idle_hold", 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, V_IDLE);

      // lw, zero-wait memory: 5 cycles
      step("lw_idle",  1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_IDLE);
      step("lw_fetch", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_F_RDY);
      step("lw_dec",   1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_DEC);
      step("lw_exec",  1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_E_MEM);
      step("lw_mem",   1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_M_LW);
      step("lw_wb",    1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_WB_LW);

      // beq taken then not taken: 3 cycles each
      step("beq1_fetch", 1'b1, 3'b110, 3'b000, 1'b1, 1'b1, V_F_RDY);
      step("beq1_dec",   1'b1, 3'b110, 3'b000, 1'b1, 1'b1, V_DEC);
      step("beq1_exec",  1'b1, 3'b110, 3'b000, 1'b1, 1'b1, V_E_BEQ1);
      step("beq0_fetch", 1'b1, 3'b110, 3'b000, 1'b0, 1'b1, V_F_RDY);
      step("beq0_dec",   1'b1, 3'b110, 3'b000, 1'b0, 1'b1, V_DEC);
      step("beq0_exec",  1'b1, 3'b110, 3'b000, 1'b0, 1'b1, V_E_BEQ0);

      // R xor then srl
      step("xor_fetch", 1'b1, 3'b011, 3'b100, 1'b0, 1'b1, V_F_RDY);
      step("xor_dec",   1'b1, 3'b011, 3'b100, 1'b0, 1'b1, V_DEC);
      step("xor_exec",  1'b1, 3'b011, 3'b100, 1'b0, 1'b1, V_E_XOR);
      step("xor_wb",    1'b1, 3'b011, 3'b100, 1'b0, 1'b1, V_WB_R);
      step("srl_fetch", 1'b1, 3'b011, 3'b101, 1'b0, 1'b1, V_F_RDY);
      step("srl_dec",   1'b1, 3'b011, 3'b101, 1'b0, 1'b1, V_DEC);
      step("srl_exec",  1'b1, 3'b011, 3'b101, 1'b0, 1'b1, V_E_SRL);
      step("srl_wb",    1'b1, 3'b011, 3'b101, 1'b0, 1'b1, V_WB_R);

      // sw with 3 wait cycles; tipo wiggles after DECODE must be ignored
      step("sw_fetch", 1'b1, 3'b010, 3'b000, 1'b0, 1'b1, V_F_RDY);
      step("sw_dec",   1'b1, 3'b010, 3'b000, 1'b0, 1'b1, V_DEC);
      step("sw_exec",  1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_E_MEM);
      for (int i = 0; i < 3; i++)
         step("sw_mem_wait", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, V_M_SW);
      step("sw_mem_done", 1'b1, 3'b011, 3'b000, 1'b0, 1'b1, V_M_SWD);

      // run dropped mid R sub: completes, then parks in IDLE
      step("sub_fetch", 1'b1, 3'b011, 3'b000, 1'b0, 1'b1, V_F_RDY);
      step("sub_dec",   1'b0, 3'b011, 3'b000, 1'b0, 1'b1, V_DEC);
      step("sub_exec",  1'b0, 3'b011, 3'b000, 1'b0, 1'b1, V_E_SUB);
      step("sub_wb",    1'b0, 3'b011, 3'b000, 1'b0, 1'b1, V_WB_R);
      step("sub_park",  1'b0, 3'b011, 3'b000, 1'b0, 1'b1, V_IDLE);

      // 14 stalled fetch cycles, ready on the limit cycle wins; then illegal tipo -> ERR
      step("tol_idle", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, V_IDLE);
      for (int i = 0; i < 14; i++)
         step("tol_wait", 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, V_F_WAIT);
      step("tol_limit_rdy", 1'b1, 3'b111, 3'b000, 1'b0, 1'b1, V_F_RDY);
      step("ill_dec",       1'b1, 3'b111, 3'b000, 1'b0, 1'b1, V_DEC);
      for (int i = 0; i < 3; i++)
         step("ill_err_hold", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_ERR);
      reset_pulse("err_reset");

      // async reset while stalled in MEM
      step("rst_idle", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_IDLE);
      step("rst_fetch", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_F_RDY);
      step("rst_dec",   1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_DEC);
      step("rst_exec",  1'b1, 3'b000, 3'b000, 1'b0, 1'b0, V_E_MEM);
      step("rst_mem",   1'b1, 3'b000, 3'b000, 1'b0, 1'b0, V_M_LW);
      reset_pulse("rst_in_mem");

      // fetch stuck low 15 cycles -> ERR
      step("to_idle", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, V_IDLE);
      for (int i = 0; i < 15; i++)
         step("to_wait", 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, V_F_WAIT);
      step("to_err", 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, V_ERR);
      reset_pulse("to_reset");

      // R with illegal funct3 -> ERR
      step("f3_idle",  1'b1, 3'b011, 3'b001, 1'b0, 1'b1, V_IDLE);
      step("f3_fetch", 1'b1, 3'b011, 3'b001, 1'b0, 1'b1, V_F_RDY);
      step("f3_dec",   1'b1, 3'b011, 3'b001, 1'b0, 1'b1, V_DEC);
      step("f3_err",   1'b0, 3'b011, 3'b000, 1'b0, 1'b1, V_ERR);

`ifndef MC_PERFCNT_EN
      check("cycles_tied", cycles, 32'd0);
      check("retired_tied", retired, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
